// File: rtl/mem_arb_pkg.sv
// Shared types and requester ids for the core memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_HOLD
    } arb_state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    function automatic logic [1:0] id_onehot(input logic id);
        return (id == REQ_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker: round-robin against the last grant, or LSU-first when FIXED_PRIO is set.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] i_cand,
    input  logic       i_rr_last,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_winner = REQ_IFU;
        o_grant  = 2'b00;
        if (i_cand == 2'b11) begin
            o_winner = (FIXED_PRIO != 0) ? REQ_LSU : ~i_rr_last;
        end else if (i_cand[1]) begin
            o_winner = REQ_LSU;
        end
        if (i_cand != 2'b00) begin
            o_grant = id_onehot(o_winner);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single core memory port between instruction fetch (m0) and load/store (m1),
// with an m1 lock that keeps both halves of a misaligned access back to back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          m0_reqValid,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_wen,
    input  logic [3:0]    m0_wmask,
    input  logic [1:0]    m0_size,
    output logic          m0_respValid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_reqValid,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_wen,
    input  logic [3:0]    m1_wmask,
    input  logic [1:0]    m1_size,
    output logic          m1_respValid,
    output logic [DW-1:0] m1_rdata,
    input  logic          m1_lock,

    output logic          mem_reqValid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    output logic [3:0]    mem_wmask,
    output logic [1:0]    mem_size,
    input  logic          mem_respValid,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] LOCK_TO = 8'(LOCK_TIMEOUT);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] r_pend;
    logic [1:0] w_pend_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_rr_last;
    logic       w_rr_last_nxt;
    logic [7:0] r_lock_cnt;
    logic [7:0] w_lock_cnt_nxt;
    logic [7:0] w_lock_inc;

    logic [1:0] w_req;
    logic [1:0] w_cand;
    logic [1:0] w_grant;
    logic       w_winner;
    logic       w_sel_m1;
    logic       w_resp;

    assign w_req      = {m1_reqValid, m0_reqValid};
    assign w_cand     = r_pend | w_req;
    assign w_lock_inc = r_lock_cnt + 8'd1;

    mem_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_cand    (w_cand),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant),
        .o_winner  (w_winner)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_pend     <= 2'b00;
            r_owner    <= REQ_IFU;
            r_rr_last  <= REQ_IFU;
            r_lock_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Pulses are folded into pend every cycle so none is lost; only the issued one is cleared.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend | w_req;
        w_owner_nxt    = r_owner;
        w_rr_last_nxt  = r_rr_last;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_cand != 2'b00) begin
                    w_owner_nxt   = w_winner;
                    w_rr_last_nxt = w_winner;
                    w_pend_nxt    = w_pend_nxt & ~w_grant;
                    w_state_nxt   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_respValid) begin
                    if ((r_owner == REQ_LSU) && m1_lock) begin
                        w_state_nxt    = ARB_HOLD;
                        w_lock_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            ARB_HOLD: begin
                if (w_cand[1]) begin
                    w_pend_nxt[1] = 1'b0;
                    w_state_nxt   = ARB_ISSUE;
                end else begin
                    w_lock_cnt_nxt = w_lock_inc;
                    if (w_lock_inc == LOCK_TO) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign mem_reqValid = (r_state == ARB_ISSUE);
    assign w_sel_m1     = (r_state != ARB_IDLE) && (r_owner == REQ_LSU);

    // Payload follows the owner's live inputs; IDLE shows m0 with the write strobe suppressed.
    assign mem_addr  = w_sel_m1 ? m1_addr  : m0_addr;
    assign mem_wdata = w_sel_m1 ? m1_wdata : m0_wdata;
    assign mem_wmask = w_sel_m1 ? m1_wmask : m0_wmask;
    assign mem_size  = w_sel_m1 ? m1_size  : m0_size;
    assign mem_wen   = (r_state == ARB_IDLE) ? 1'b0 : (w_sel_m1 ? m1_wen : m0_wen);

    assign w_resp       = (r_state == ARB_WAIT) && mem_respValid;
    assign m0_respValid = w_resp && (r_owner == REQ_IFU);
    assign m1_respValid = w_resp && (r_owner == REQ_LSU);
    assign m0_rdata     = mem_rdata;
    assign m1_rdata     = mem_rdata;

endmodule
